conv_window_buffer: RTL and testbench

Streaming 3x3 sliding-window generator for the convolution datapath. It sits between the AXI-Stream pixel input and the conv control FSM. It accepts raster-order pixels only while the FSM grants a phase (fill / calc / wrap), buffers two image lines, and emits one 3x3 window per valid position. It returns the phase-completion strobes (fill_done, row_done, wrap_done, frame_done) that drive the FSM's transitions.

---
 rtl/conv_window_buffer.sv | 166 ++++++++++++++++
 tb/tb_conv_window_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
// Streaming 3x3 sliding-window generator: buffers two image lines, gates pixel
// intake on the conv FSM's phase grants and reports phase-completion strobes.
module conv_window_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  localparam int RW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W)
) (
  input  logic                S_AXIS_ACLK,
  input  logic                S_AXIS_ARESETN,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic                S_AXIS_TVALID,
  input  logic                S_AXIS_TLAST,
  output logic                S_AXIS_TREADY,
  input  logic                fill_en,
  input  logic                calc_en,
  input  logic                wrap_en,
  output logic                din_valid,
  output logic                fill_done,
  output logic                row_done,
  output logic                wrap_done,
  output logic                frame_done,
  output logic [9*DATA_W-1:0] win_data,
  output logic [RW-1:0]       win_row,
  output logic [CW-1:0]       win_col,
  output logic                win_valid,
  output logic                proto_err
);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                last_row_q, last_row_d;
  logic                eof_hold_q, eof_hold_d;
  logic                proto_err_q, proto_err_d;
  logic [DATA_W-1:0]   line0_q [IMG_W];
  logic [DATA_W-1:0]   line0_d [IMG_W];
  logic [DATA_W-1:0]   line1_q [IMG_W];
  logic [DATA_W-1:0]   line1_d [IMG_W];
  logic [9*DATA_W-1:0] sw_q, sw_d;
  logic [9*DATA_W-1:0] win_data_q, win_data_d;
  logic                win_valid_q, win_valid_d;
  logic [RW-1:0]       win_row_q, win_row_d;
  logic [CW-1:0]       win_col_q, win_col_d;

  logic [1:0] grant_cnt;
  logic       one_grant, multi_grant, hold, tready, accept, last_px, win_fire;

  always_comb begin
    grant_cnt   = 2'(fill_en) + 2'(calc_en) + 2'(wrap_en);
    one_grant   = (grant_cnt == 2'd1);
    multi_grant = (grant_cnt >= 2'd2);
    // eof_hold_q keeps the hold alive after last_row clears, for as long as wrap_en stays high
    hold        = wrap_en && (last_row_q || eof_hold_q);
    tready      = one_grant && !hold;
    accept      = S_AXIS_TVALID && tready;
    last_px     = (row_q == ROW_LAST) && (col_q == COL_LAST);
    win_fire    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  end

  assign S_AXIS_TREADY = tready;
  assign din_valid     = S_AXIS_TVALID && !(fill_en || calc_en || wrap_en);
  assign fill_done     = accept && fill_en && (row_q == RW'(2)) && (col_q == CW'(2));
  assign row_done      = accept && calc_en && (col_q == COL_LAST);
  assign wrap_done     = (accept && wrap_en && (col_q == CW'(1))) || hold;
  assign frame_done    = hold;
  assign win_data      = win_data_q;
  assign win_row       = win_row_q;
  assign win_col       = win_col_q;
  assign win_valid     = win_valid_q;
  assign proto_err     = proto_err_q;

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    last_row_d  = last_row_q;
    eof_hold_d  = hold;
    proto_err_d = proto_err_q || multi_grant || (accept && (S_AXIS_TLAST != last_px));
    line0_d     = line0_q;
    line1_d     = line1_q;
    sw_d        = sw_q;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_valid_d = win_fire;

    if (hold) begin
      row_d      = '0;
      col_d      = '0;
      last_row_d = 1'b0;
    end

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d      = '0;
          last_row_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end

      // line0 tail is the pixel one row above, line1 tail two rows above
      line0_d[0] = S_AXIS_TDATA;
      line1_d[0] = line0_q[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        line0_d[i] = line0_q[i-1];
        line1_d[i] = line1_q[i-1];
      end

      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          sw_d[(3*r+c)*DATA_W +: DATA_W] = sw_q[(3*r+c+1)*DATA_W +: DATA_W];
        end
      end
      sw_d[2*DATA_W +: DATA_W] = line1_q[IMG_W-1];
      sw_d[5*DATA_W +: DATA_W] = line0_q[IMG_W-1];
      sw_d[8*DATA_W +: DATA_W] = S_AXIS_TDATA;
    end

    if (win_fire) begin
      win_data_d = sw_d;
      win_row_d  = row_q - RW'(2);
      win_col_d  = col_q - CW'(2);
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      row_q       <= '0;
      col_q       <= '0;
      last_row_q  <= 1'b0;
      eof_hold_q  <= 1'b0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        line0_q[i] <= '0;
        line1_q[i] <= '0;
      end
      sw_q        <= '0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      last_row_q  <= last_row_d;
      eof_hold_q  <= eof_hold_d;
      proto_err_q <= proto_err_d;
      line0_q     <= line0_d;
      line1_q     <= line1_d;
      sw_q        <= sw_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_valid_q <= win_valid_d;
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: a small conv-FSM model drives the phase grants,
// and expected windows are cut straight out of the frame image array.
module tb_conv_window_buffer;
  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam int EW = 9*DW + RW + CW;

  typedef enum int {P_FILL, P_CALC, P_WRAP, P_EOF, P_IDLE} phase_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]   s_tdata;
  logic            s_tvalid, s_tlast, s_tready;
  logic            fill_en, calc_en, wrap_en;
  logic            din_valid, fill_done, row_done, wrap_done, frame_done;
  logic [9*DW-1:0] win_data;
  logic [RW-1:0]   win_row;
  logic [CW-1:0]   win_col;
  logic            win_valid, proto_err;

  conv_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TREADY  (s_tready),
    .fill_en        (fill_en),
    .calc_en        (calc_en),
    .wrap_en        (wrap_en),
    .din_valid      (din_valid),
    .fill_done      (fill_done),
    .row_done       (row_done),
    .wrap_done      (wrap_done),
    .frame_done     (frame_done),
    .win_data       (win_data),
    .win_row        (win_row),
    .win_col        (win_col),
    .win_valid      (win_valid),
    .proto_err      (proto_err)
  );

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  int win_cnt;
  logic [DW-1:0] frame_px [N];
  logic [EW-1:0] exp_q[$];

  task automatic idle_inputs();
    fill_en  = 1'b0;
    calc_en  = 1'b0;
    wrap_en  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_ramp(input int base);
    for (int i = 0; i < N; i++) frame_px[i] = DW'(base + i);
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) frame_px[i] = DW'($urandom_range(255));
  endtask

  // Drives one frame through the FSM phases; abort_at >= 0 stops after that many accepts.
  task automatic run_frame(input int gap_pct, input int bad_last_idx, input int abort_at);
    int k, cyc, r, c;
    phase_t phase;
    bit exp_win, exp_acc, aborted;
    logic [EW-1:0] exp_e, got_e;
    logic [3:0] exp_s, got_s;
    k = 0; cyc = 0; phase = P_FILL; exp_win = 0; aborted = 0; win_cnt = 0;
    while (phase != P_IDLE) begin
      @(negedge clk);
      vectors++;
      if (win_valid !== exp_win) begin
        miscompares++;
        $display("FAIL win_valid k=%0d got %b expected %b", k, win_valid, exp_win);
      end
      if (win_valid === 1'b1) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL win_extra k=%0d got row=%0d col=%0d expected no window", k, win_row, win_col);
        end else begin
          exp_e = exp_q.pop_front();
          got_e = {win_row, win_col, win_data};
          vectors++;
          if (got_e !== exp_e) begin
            miscompares++;
            $display("FAIL win_content k=%0d got %h expected %h", k, got_e, exp_e);
          end
        end
      end
      exp_win = 0;
      if (cyc >= 500) begin
        miscompares++;
        $display("FAIL frame_timeout k=%0d got phase %0d expected idle", k, phase);
        aborted = 1;
        break;
      end
      fill_en  = (phase == P_FILL);
      calc_en  = (phase == P_CALC);
      wrap_en  = (phase == P_WRAP) || (phase == P_EOF);
      s_tvalid = (phase == P_EOF) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      s_tdata  = frame_px[(k < N) ? k : 0];
      s_tlast  = (k == N-1) ^ (k == bad_last_idx);
      #1;
      r = k / W;
      c = k % W;
      exp_acc = s_tvalid && (phase != P_EOF);
      vectors++;
      if (s_tready !== (phase != P_EOF)) begin
        miscompares++;
        $display("FAIL tready k=%0d phase=%0d got %b expected %b", k, phase, s_tready, phase != P_EOF);
      end
      exp_s = {exp_acc && phase == P_FILL && k == 2*W+2,
               exp_acc && phase == P_CALC && c == W-1,
               (exp_acc && phase == P_WRAP && c == 1) || phase == P_EOF,
               phase == P_EOF};
      got_s = {fill_done, row_done, wrap_done, frame_done};
      vectors++;
      if (got_s !== exp_s) begin
        miscompares++;
        $display("FAIL strobes k=%0d {fill,row,wrap,frame} got %b expected %b", k, got_s, exp_s);
      end
      if (exp_acc) begin
        if (r >= 2 && c >= 2) begin
          exp_e = '0;
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              exp_e[(3*rr+cc)*DW +: DW] = frame_px[(r-2+rr)*W + (c-2+cc)];
          exp_e[9*DW +: CW]    = CW'(c-2);
          exp_e[9*DW+CW +: RW] = RW'(r-2);
          exp_q.push_back(exp_e);
          exp_win = 1;
        end
        k++;
      end
      case (phase)
        P_FILL:  if (exp_s[3]) phase = P_CALC;
        P_CALC:  if (exp_s[2]) phase = (r == H-1) ? P_EOF : P_WRAP;
        P_WRAP:  if (exp_s[1]) phase = P_CALC;
        default: phase = P_IDLE;
      endcase
      cyc++;
      if (abort_at >= 0 && k == abort_at) begin
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      idle_inputs();
      #1;
      vectors++;
      if ({win_valid, s_tready, frame_done} !== {exp_win, 2'b00}) begin
        miscompares++;
        $display("FAIL idle_after_frame got win_valid/tready/frame_done %b expected %b", {win_valid, s_tready, frame_done}, {exp_win, 2'b00});
      end
      if (win_valid === 1'b1) win_cnt++;
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL windows_missing got %0d pending expected 0", exp_q.size());
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({s_tready, din_valid, fill_done, row_done, wrap_done, frame_done, win_valid, proto_err,
         win_row, win_col, win_data} !== '0) begin
      miscompares++;
      $display("FAIL %s got win_data=%h row=%0d col=%0d ctl=%b expected all zero", name, win_data, win_row, win_col,
               {s_tready, din_valid, fill_done, row_done, wrap_done, frame_done, win_valid, proto_err});
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_directed_frame();
    load_ramp(0);
    run_frame(0, -1, -1);
    vectors++;
    if (win_cnt != 6 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL directed_frame got windows=%0d proto_err=%b expected 6 and 0", win_cnt, proto_err);
    end
  endtask

  task automatic test_back_to_back();
    load_ramp(100);
    run_frame(30, -1, -1);
    vectors++;
    if (win_cnt != 6 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back got windows=%0d proto_err=%b expected 6 and 0", win_cnt, proto_err);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      load_random();
      run_frame($urandom_range(50), -1, -1);
      vectors++;
      if (win_cnt != 6) begin
        miscompares++;
        $display("FAIL random_frame%0d got windows=%0d expected 6", f, win_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    load_random();
    run_frame(0, -1, 10);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("reset_mid_frame");
    @(negedge clk);
    rst_n = 1'b1;
    load_ramp(40);
    run_frame(20, -1, -1);
    vectors++;
    if (win_cnt != 6 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_frame got windows=%0d proto_err=%b expected 6 and 0", win_cnt, proto_err);
    end
  endtask

  task automatic test_tlast_errors();
    load_ramp(0);
    run_frame(0, 7, -1);
    vectors++;
    if (win_cnt != 6 || proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL early_tlast got windows=%0d proto_err=%b expected 6 and 1", win_cnt, proto_err);
    end
    do_reset();
    load_random();
    run_frame(10, N-1, -1);
    vectors++;
    if (win_cnt != 6 || proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL missing_tlast got windows=%0d proto_err=%b expected 6 and 1", win_cnt, proto_err);
    end
    do_reset();
  endtask

  task automatic test_multi_grant();
    @(negedge clk);
    fill_en = 1'b1; calc_en = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h55;
    #1;
    vectors++;
    if ({s_tready, fill_done, proto_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL multi_grant_ready got tready/fill_done/proto_err %b expected 000", {s_tready, fill_done, proto_err});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL multi_grant_err got %b expected 1", proto_err);
    end
    do_reset();
  endtask

  task automatic test_din_valid();
    @(negedge clk);
    s_tvalid = 1'b1;
    #1;
    vectors++;
    if ({din_valid, s_tready} !== 2'b10) begin
      miscompares++;
      $display("FAIL din_valid_pending got din_valid/tready %b expected 10", {din_valid, s_tready});
    end
    calc_en = 1'b1;
    #1;
    vectors++;
    if (din_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL din_valid_granted got %b expected 0", din_valid);
    end
    idle_inputs();
    #1;
    vectors++;
    if ({din_valid, proto_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL din_valid_idle got din_valid/proto_err %b expected 00", {din_valid, proto_err});
    end
  endtask

  initial begin
    test_reset();
    test_directed_frame();
    test_back_to_back();
    test_random_frames();
    test_reset_mid_frame();
    test_tlast_errors();
    test_multi_grant();
    test_din_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
